sram_1rw_array_ctrl: RTL and testbench
======================================

Name: sram_1rw_array_ctrl

Overview:
Parametrised successor to the fixed 15x4096 single-port array wrappers. It provides a behavioural 1RW storage array with these features:
- configurable width, depth and write-mask granularity
- optional registered read output
- hardware clear sequencer that zeroes every entry after reset or on request, with ready/valid signalling

It sits between cache/predictor table logic and the storage, so callers no longer need their own init sweeps.

Parameters:
WIDTH, 15, data bits per entry
DEPTH, 4096, number of entries (need not be a power of two)
ADDR_W, $clog2(DEPTH), address width
MASK_GRAN, 1, data bits per mask bit; WIDTH must be a multiple of MASK_GRAN
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2
CLEAR_ON_RESET, 1, 1 = run the clear sweep automatically after reset

Ports:
RW0_clk  input  1  single clock; all logic on the rising edge
RW0_reset  input  1  asynchronous, active-high reset
RW0_addr  input  ADDR_W  access address
RW0_en  input  1  access request, sampled when RW0_ready=1
RW0_wmode  input  1  1 = write, 0 = read
RW0_wdata  input  WIDTH  write data
RW0_wmask  input  WIDTH/MASK_GRAN  per-group write enable
RW0_clr  input  1  single-cycle pulse requesting a full clear sweep
RW0_ready  output  1  array accepts requests
RW0_rdata  output  WIDTH  read data
RW0_rvalid  output  1  one-cycle pulse marking new RW0_rdata

Behaviour:
- Reset (async assert) drives:
  - RW0_rdata=0, RW0_rvalid=0, sweep counter=0, pipeline valids=0.
  - State=CLEAR and RW0_ready=0 if CLEAR_ON_RESET=1; otherwise state=IDLE and RW0_ready=1.
  - Array contents are not reset directly.
- State machine has two states, IDLE and CLEAR:
  - CLEAR: each cycle, write all-zero to entry[counter] and increment the counter. When counter==DEPTH-1, the write completes and the FSM goes to IDLE. RW0_ready=1 from the following cycle.
  - The sweep takes exactly DEPTH cycles.
  - IDLE: when RW0_clr=1, go to CLEAR on the next edge with counter=0 and RW0_ready=0. The request issued in the same cycle as RW0_clr is still executed.
  - RW0_clr is ignored while in CLEAR; the sweep is not restarted.
- Requests are accepted only when RW0_en & RW0_ready. Requests presented while RW0_ready=0 are dropped: no write, no rvalid.
- Write (accepted, RW0_wmode=1):
  - For each mask bit i, bits [i*MASK_GRAN +: MASK_GRAN] are updated only if RW0_wmask[i]=1.
  - An all-zero mask is a no-op.
  - RW0_rdata and RW0_rvalid are unaffected.
- Read (accepted, RW0_wmode=0):
  - OUT_REG=0: data appears on RW0_rdata with RW0_rvalid=1 at the edge after acceptance.
  - OUT_REG=1: data appears one edge later. Back-to-back reads are fully pipelined, one per cycle.
  - RW0_rdata holds its last read value until the next read completes; it does not change on writes or during a sweep.
- Read-after-write to the same address in the following cycle returns the newly written data. No read-during-write in the same cycle exists (single port).
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of two):
  - A write is ignored.
  - A read completes normally (rvalid pulses) with RW0_rdata=0.
- A reset asserted mid-sweep or mid-read aborts everything:
  - In-flight reads are discarded (no rvalid).
  - The sweep restarts from 0 after deassert if CLEAR_ON_RESET=1.
- A read in flight when a sweep begins still completes with the pre-clear data.

Test Plan:
- Sweep length (WIDTH=15, DEPTH=16, CLEAR_ON_RESET=1): release reset -> RW0_ready=0 for exactly 16 cycles, then 1; a read of every address returns 0x0000.
- Basic access (OUT_REG=0): write 0x5A5A to addr 3 with full mask, read addr 3 in the next cycle -> RW0_rdata=0x5A5A with RW0_rvalid pulsing exactly 1 cycle after acceptance; with OUT_REG=1 the result arrives 2 cycles after acceptance.
- Partial mask (MASK_GRAN=5, WIDTH=15): write 0x7FFF to addr 7, then write 0x0000 with mask 3'b010 -> read returns 0x7C1F.
- Requests while not ready: issue a write of 0x1234 to addr 2 during the sweep, then read addr 2 -> 0x0000; no rvalid for any request issued while RW0_ready=0.
- RW0_clr in IDLE: fill addresses 0-15 with nonzero data, pulse RW0_clr -> ready drops for 16 cycles and all reads return 0. A second RW0_clr mid-sweep does not extend the sweep.
- Non-power-of-two depth and reset mid-sweep (DEPTH=12, ADDR_W=4): write to addr 13 is ignored and a read of addr 13 returns 0 with rvalid. Assert reset at sweep count 5 -> after release, RW0_ready=0 for a full 12 cycles.

Source files
------------

// File: rtl/sram_1rw_array_ctrl.sv
// Behavioural single-port (1RW) storage array with per-group write mask, optional
// output register and a zero-fill sweep that runs after reset and on request.
module sram_1rw_array_ctrl #(
    parameter int WIDTH          = 15,
    parameter int DEPTH          = 4096,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int MASK_GRAN      = 1,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       RW0_clk,
    input  logic                       RW0_reset,
    input  logic [ADDR_W-1:0]          RW0_addr,
    input  logic                       RW0_en,
    input  logic                       RW0_wmode,
    input  logic [WIDTH-1:0]           RW0_wdata,
    input  logic [WIDTH/MASK_GRAN-1:0] RW0_wmask,
    input  logic                       RW0_clr,
    output logic                       RW0_ready,
    output logic [WIDTH-1:0]           RW0_rdata,
    output logic                       RW0_rvalid
);

    localparam int                NGRP     = WIDTH / MASK_GRAN;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       DEPTH_U  = 32'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    function automatic logic [WIDTH-1:0] expand_mask(input logic [NGRP-1:0] grp_mask);
        logic [WIDTH-1:0] bits;
        for (int i = 0; i < WIDTH; i++) begin
            bits[i] = grp_mask[i / MASK_GRAN];
        end
        return bits;
    endfunction

    logic [WIDTH-1:0]  mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q;
    logic              rvalid_q;
    logic [WIDTH-1:0]  rdata_q;

    logic              acc_s, wr_s, rd_s, in_range_s;
    logic [WIDTH-1:0]  rd_word_s, bitmask_s, merged_s;
    logic              out_v_s;
    logic [WIDTH-1:0]  out_d_s;

    // Request decode and read-modify-write merge of the masked groups.
    always_comb begin
        in_range_s = (32'(RW0_addr) < DEPTH_U);
        acc_s      = RW0_en & ready_q;
        wr_s       = acc_s & RW0_wmode & in_range_s;
        rd_s       = acc_s & ~RW0_wmode;
        if (in_range_s) begin
            rd_word_s = mem_q[RW0_addr];
        end else begin
            rd_word_s = {WIDTH{1'b0}};
        end
        bitmask_s = expand_mask(RW0_wmask);
        merged_s  = (rd_word_s & ~bitmask_s) | (RW0_wdata & bitmask_s);
    end

    // Next-state logic for the idle / clear-sweep sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (RW0_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d   = {ADDR_W{1'b0}};
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Sequencer state, sweep counter and registered ready.
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state_q <= RST_STATE;
            cnt_q   <= {ADDR_W{1'b0}};
            ready_q <= (RST_STATE == ST_IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Storage: sweep writes zero; accepted writes can only occur in IDLE.
    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            mem_q[0] <= mem_q[0];
        end else if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= {WIDTH{1'b0}};
        end else if (wr_s) begin
            mem_q[RW0_addr] <= merged_s;
        end
    end

    // Read data is captured at acceptance, so a later sweep cannot alter it.
    if (OUT_REG != 0) begin : g_out_reg
        logic             s1_v_q;
        logic [WIDTH-1:0] s1_d_q;

        always_ff @(posedge RW0_clk or posedge RW0_reset) begin
            if (RW0_reset) begin
                s1_v_q <= 1'b0;
                s1_d_q <= {WIDTH{1'b0}};
            end else begin
                s1_v_q <= rd_s;
                if (rd_s) begin
                    s1_d_q <= rd_word_s;
                end
            end
        end

        assign out_v_s = s1_v_q;
        assign out_d_s = s1_d_q;
    end else begin : g_no_out_reg
        assign out_v_s = rd_s;
        assign out_d_s = rd_word_s;
    end

    // Final read stage; rdata holds until the next read completes.
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= {WIDTH{1'b0}};
        end else begin
            rvalid_q <= out_v_s;
            if (out_v_s) begin
                rdata_q <= out_d_s;
            end
        end
    end

    assign RW0_ready  = ready_q;
    assign RW0_rvalid = rvalid_q;
    assign RW0_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_1rw_array_ctrl.sv
// Two configurations side by side: A (DEPTH=12, MASK_GRAN=5, latency 1) and
// B (DEPTH=16, MASK_GRAN=1, latency 2), each against a behavioural model.
module tb_sram_1rw_array_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        en, wm, clr;
    logic [1:0][3:0]   addr;
    logic [1:0][14:0]  wdata, wmask;
    logic [1:0]        rdy, rv;
    logic [1:0][14:0]  rd;

    int n_cmp = 0;
    int n_err = 0;

    logic [14:0] mm [2][16];
    int          busy [2];
    logic        dv [2][3];
    logic [14:0] dd [2][3];
    logic [14:0] exp_rd [2];

    always #5 clk = ~clk;

    sram_1rw_array_ctrl #(.WIDTH(15), .DEPTH(12), .ADDR_W(4), .MASK_GRAN(5),
                          .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr[0]), .RW0_en(en[0]),
        .RW0_wmode(wm[0]), .RW0_wdata(wdata[0]), .RW0_wmask(wmask[0][2:0]),
        .RW0_clr(clr[0]), .RW0_ready(rdy[0]), .RW0_rdata(rd[0]), .RW0_rvalid(rv[0]));

    sram_1rw_array_ctrl #(.WIDTH(15), .DEPTH(16), .ADDR_W(4), .MASK_GRAN(1),
                          .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr[1]), .RW0_en(en[1]),
        .RW0_wmode(wm[1]), .RW0_wdata(wdata[1]), .RW0_wmask(wmask[1]),
        .RW0_clr(clr[1]), .RW0_ready(rdy[1]), .RW0_rdata(rd[1]), .RW0_rvalid(rv[1]));

    function automatic int dep(int k);  return (k == 0) ? 12 : 16; endfunction
    function automatic int gran(int k); return (k == 0) ? 5 : 1;   endfunction
    function automatic int lat(int k);  return (k == 0) ? 1 : 2;   endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy[k]   = dep(k);
            exp_rd[k] = 15'h0;
            for (int s = 0; s < 3; s++) begin
                dv[k][s] = 1'b0;
                dd[k][s] = 15'h0;
            end
        end
    endtask

    // One clock edge of the reference: sweep, or accept one request.
    task automatic model_edge(int k);
        dv[k][0] = dv[k][1]; dd[k][0] = dd[k][1];
        dv[k][1] = dv[k][2]; dd[k][1] = dd[k][2];
        dv[k][2] = 1'b0;
        if (busy[k] > 0) begin
            mm[k][dep(k) - busy[k]] = 15'h0;
            busy[k]--;
        end else begin
            if (en[k] && wm[k]) begin
                if (int'(addr[k]) < dep(k)) begin
                    for (int b = 0; b < 15; b++) begin
                        if (wmask[k][b / gran(k)]) mm[k][addr[k]][b] = wdata[k][b];
                    end
                end
            end else if (en[k]) begin
                dv[k][lat(k) - 1] = 1'b1;
                dd[k][lat(k) - 1] = (int'(addr[k]) < dep(k)) ? mm[k][addr[k]] : 15'h0;
            end
            if (clr[k]) busy[k] = dep(k);
        end
        if (dv[k][0]) exp_rd[k] = dd[k][0];
    endtask

    task automatic check_out();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k),  32'(rdy[k]), 32'(busy[k] == 0));
            chk($sformatf("rvalid%0d", k), 32'(rv[k]),  32'(dv[k][0]));
            chk($sformatf("rdata%0d", k),  32'(rd[k]),  32'(exp_rd[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_out();
    endtask

    task automatic idle_in();
        en = 2'b00; wm = 2'b00; clr = 2'b00;
        addr = '0; wdata = '0; wmask = '0;
    endtask

    task automatic set_op(int k, logic e, logic w, logic [3:0] a, logic [14:0] d, logic [14:0] m);
        en[k] = e; wm[k] = w; addr[k] = a; wdata[k] = d; wmask[k] = m;
    endtask

    task automatic rand_in();
        for (int k = 0; k < 2; k++) begin
            en[k]    = ($urandom_range(0, 3) != 0);
            wm[k]    = 1'($urandom_range(0, 1));
            addr[k]  = 4'($urandom_range(0, 15));
            wdata[k] = 15'($urandom);
            wmask[k] = ($urandom_range(0, 1) == 1) ? 15'h7FFF : 15'($urandom);
            clr[k]   = ($urandom_range(0, 99) == 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) mm[k][a] = 15'h0;
        idle_in();
        model_reset();
        #2;
        check_out();
        #10;
        rst = 1'b0;
        repeat (20) step();

        // every address reads back zero after the power-on sweep
        for (int a = 0; a < 16; a++) begin
            set_op(0, 1'b1, 1'b0, 4'(a), 15'h0, 15'h0);
            set_op(1, 1'b1, 1'b0, 4'(a), 15'h0, 15'h0);
            step();
        end
        idle_in();
        repeat (3) step();

        // write then read the next cycle; latency 1 on A, 2 on B
        set_op(0, 1'b1, 1'b1, 4'd3, 15'h5A5A, 15'h7FFF);
        set_op(1, 1'b1, 1'b1, 4'd3, 15'h5A5A, 15'h7FFF);
        step();
        set_op(0, 1'b1, 1'b0, 4'd3, 15'h0, 15'h0);
        set_op(1, 1'b1, 1'b0, 4'd3, 15'h0, 15'h0);
        step();
        chk("basic_a_rvalid", 32'(rv[0]), 32'd1);
        chk("basic_a_rdata",  32'(rd[0]), 32'h5A5A);
        chk("basic_b_early",  32'(rv[1]), 32'd0);
        idle_in();
        step();
        chk("basic_b_rvalid", 32'(rv[1]), 32'd1);
        chk("basic_b_rdata",  32'(rd[1]), 32'h5A5A);
        chk("basic_a_pulse",  32'(rv[0]), 32'd0);

        // partial mask with 5-bit groups
        set_op(0, 1'b1, 1'b1, 4'd7, 15'h7FFF, 15'h0007);
        step();
        set_op(0, 1'b1, 1'b1, 4'd7, 15'h0000, 15'h0002);
        step();
        set_op(0, 1'b1, 1'b0, 4'd7, 15'h0, 15'h0);
        step();
        chk("mask_rdata", 32'(rd[0]), 32'h7C1F);

        // out-of-range address on the 12-deep array
        set_op(0, 1'b1, 1'b1, 4'd13, 15'h7FFF, 15'h0007);
        step();
        set_op(0, 1'b1, 1'b0, 4'd13, 15'h0, 15'h0);
        step();
        chk("oor_rvalid", 32'(rv[0]), 32'd1);
        chk("oor_rdata",  32'(rd[0]), 32'h0);
        idle_in();
        step();

        // fill, clear, requests during the sweep, second clear mid-sweep
        for (int a = 0; a < 16; a++) begin
            set_op(0, 1'b1, 1'b1, 4'(a), 15'(a + 16'h101), 15'h7FFF);
            set_op(1, 1'b1, 1'b1, 4'(a), 15'(a + 16'h101), 15'h7FFF);
            step();
        end
        idle_in();
        clr = 2'b11;
        step();
        clr = 2'b00;
        for (int c = 0; c < 20; c++) begin
            set_op(0, 1'b1, c[0], 4'd2, 15'h1234, 15'h7FFF);
            set_op(1, 1'b1, c[0], 4'd2, 15'h1234, 15'h7FFF);
            clr = (c == 5) ? 2'b11 : 2'b00;
            if (c >= 10) begin
                en = 2'b00;
                clr = 2'b00;
            end
            step();
        end
        for (int a = 0; a < 16; a++) begin
            set_op(0, 1'b1, 1'b0, 4'(a), 15'h0, 15'h0);
            set_op(1, 1'b1, 1'b0, 4'(a), 15'h0, 15'h0);
            step();
        end
        idle_in();
        repeat (3) step();

        // reset in the middle of a sweep with a read in flight on B
        set_op(1, 1'b1, 1'b1, 4'd9, 15'h3333, 15'h7FFF);
        step();
        set_op(1, 1'b1, 1'b0, 4'd9, 15'h0, 15'h0);
        clr = 2'b11;
        step();
        idle_in();
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_out();
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();

        // randomized traffic
        repeat (3000) begin
            rand_in();
            step();
        end
        idle_in();
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
